// File: rtl/condlogic_it.sv
// Conditional-execution unit with predicated-block (IT) support.
// The base condition is checked against the architectural flag register.
// Inside a predicated block, a per-slot then/else mask replaces the
// instruction's own condition field. The unit also gates the write
// enables and the PC write, and updates the flags.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no block open; the instruction's Cond field decides
// ACTIVE | predicated block open; base/mask registers decide each slot
module condlogic_it #(
    parameter int NWE   = 4,
    parameter int MAXIT = 4,
    parameter int LW    = $clog2(MAXIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic [NWE-1:0]   WE_in,
    input  logic             ITStart,
    input  logic [3:0]       ITCond,
    input  logic [MAXIT-1:0] ITMask,
    input  logic [LW-1:0]    ITLen,
    output logic             PCSrc,
    output logic [NWE-1:0]   WE_out,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             InIT,
    output logic [LW-1:0]    ITRemain,
    output logic             ITErr
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } itState_t;

    localparam logic [3:0] CondAl = 4'b1110;

    itState_t         state;
    logic [LW-1:0]    count;
    logic [MAXIT-1:0] mask;
    logic [3:0]       base;

    logic [3:0] effCond;
    logic       lenOk;
    logic       advance;
    logic       flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = Flags;

    // ARM condition evaluation on the registered flags; 1111 never passes.
    function automatic logic checkCond(input logic [3:0] c,
                                       input logic n, input logic z,
                                       input logic cf, input logic v);
        logic r;
        r = 1'b0;
        case (c)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = cf;
            4'b0011: r = ~cf;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = cf & ~z;
            4'b1001: r = ~cf | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Select the condition that actually governs this instruction.
    // An else-slot flips bit 0, which turns AL into the never-true 1111.
    always_comb begin
        effCond = Cond;
        if (state == ACTIVE) begin
            effCond = mask[0] ? base : {base[3:1], ~base[0]};
        end else if (ITStart) begin
            effCond = CondAl;
        end
    end

    assign CondEx   = checkCond(effCond, flagN, flagZ, flagC, flagV);
    assign advance  = CondEx & en;
    assign WE_out   = WE_in & {NWE{advance}};
    assign PCSrc    = PCS & advance;
    assign lenOk    = (ITLen != '0) && (ITLen <= LW'(MAXIT));
    assign InIT     = (state == ACTIVE);
    assign ITRemain = count;

    // Flag register: NZ and CV halves written independently when the slot passes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else begin
            if (FlagW[1] && advance) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] && advance) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Block sequencer: opens a block, consumes one slot per enabled cycle,
    // closes on the last slot or on a taken PC write, and flags bad starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            mask  <= '0;
            base  <= 4'b0000;
            ITErr <= 1'b0;
        end else if (!en) begin
            ITErr <= 1'b0;
        end else begin
            ITErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (ITStart) begin
                        if (lenOk) begin
                            state <= ACTIVE;
                            count <= ITLen;
                            base  <= ITCond;
                            mask  <= ITMask;
                        end else begin
                            ITErr <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    // A nested start is reported but the slot still runs normally.
                    if (ITStart) ITErr <= 1'b1;
                    if (PCSrc) begin
                        state <= IDLE;
                        count <= '0;
                        mask  <= '0;
                    end else if (count == LW'(1)) begin
                        state <= IDLE;
                        count <= '0;
                        mask  <= mask >> 1;
                    end else begin
                        count <= count - LW'(1);
                        mask  <= mask >> 1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    mask  <= '0;
                end
            endcase
        end
    end

endmodule
